// File: rtl/dual_debouncer.sv
// Two-channel switch conditioner: synchronise each raw input, debounce it, and
// emit registered clean levels, per-channel edge pulses and a combined change strobe.

module dual_debouncer_chan #(
    parameter int   STABLE_CYCLES = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic change_next
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    // Last count value before the flip: the flip edge itself is the final qualifying sample.
    localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_x;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   flip;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    assign s_x    = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        flip    = 1'b0;

        unique case (state_q)
            ST_STABLE: begin
                if (s_x != level_q) begin
                    if (STABLE_CYCLES == 1) begin
                        flip = 1'b1;
                    end else begin
                        state_d = ST_PENDING;
                        count_d = CW'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (s_x == level_q) begin
                    state_d = ST_STABLE;
                    count_d = '0;
                end else if (count_q == LAST_COUNT) begin
                    flip = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                count_d = '0;
            end
        endcase

        if (flip) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
            count_d = '0;
            state_d = ST_STABLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= ST_STABLE;
            count_q <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    // Next-cycle change indication lets the top register pair_valid in step with the pulses.
    assign change_next = rise_d | fall_d;
endmodule

module dual_debouncer #(
    parameter int   STABLE_CYCLES = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic pair_valid
);
    logic a_change_next;
    logic b_change_next;
    logic pair_valid_q;
    logic pair_valid_d;

    dual_debouncer_chan #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES),
        .RESET_LEVEL  (RESET_LEVEL)
    ) u_chan_a (
        .clk        (clk),
        .rst        (rst),
        .raw        (raw_a),
        .level      (a),
        .rise       (a_rise),
        .fall       (a_fall),
        .change_next(a_change_next)
    );

    dual_debouncer_chan #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES),
        .RESET_LEVEL  (RESET_LEVEL)
    ) u_chan_b (
        .clk        (clk),
        .rst        (rst),
        .raw        (raw_b),
        .level      (b),
        .rise       (b_rise),
        .fall       (b_fall),
        .change_next(b_change_next)
    );

    always_comb begin
        pair_valid_d = a_change_next | b_change_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_valid_q <= 1'b0;
        end else begin
            pair_valid_q <= pair_valid_d;
        end
    end

    assign pair_valid = pair_valid_q;
endmodule

// File: tb/tb_dual_debouncer.sv
// Directed bench for dual_debouncer with default parameters (sync 2, stable 4).

module tb_dual_debouncer;
    logic clk = 1'b0;
    logic rst;
    logic raw_a;
    logic raw_b;
    logic a;
    logic b;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic pair_valid;

    int n_checks = 0;
    int n_errors = 0;

    dual_debouncer dut (
        .clk       (clk),
        .rst       (rst),
        .raw_a     (raw_a),
        .raw_b     (raw_b),
        .a         (a),
        .b         (b),
        .a_rise    (a_rise),
        .a_fall    (a_fall),
        .b_rise    (b_rise),
        .b_fall    (b_fall),
        .pair_valid(pair_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %b at %0t", tag, got, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Any pulse activity seen on the sampled ticks of a quiet window.
    logic seen_pulse;
    task automatic tick_watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            seen_pulse = seen_pulse | a_rise | a_fall | b_rise | b_fall | pair_valid;
        end
    endtask

    initial begin
        rst   = 1'b1;
        raw_a = 1'b0;
        raw_b = 1'b1;
        #1;
        check("rst_a", a, 1'b0);
        check("rst_b", b, 1'b0);
        check("rst_pv", pair_valid, 1'b0);
        tick(3);
        rst = 1'b0;

        // Release with raw_b high: b flips at release edge 6
        seen_pulse = 1'b0;
        tick_watch(5);
        check("t1_b_edge5", b, 1'b0);
        check("t1_quiet", seen_pulse, 1'b0);
        tick(1);
        check("t1_b_edge6", b, 1'b1);
        check("t1_b_rise", b_rise, 1'b1);
        check("t1_b_fall", b_fall, 1'b0);
        check("t1_pv", pair_valid, 1'b1);
        check("t1_a", a, 1'b0);
        tick(1);
        check("t1_b_rise_off", b_rise, 1'b0);
        check("t1_pv_off", pair_valid, 1'b0);
        check("t1_b_hold", b, 1'b1);

        // raw_b falls: b_fall at edge 6
        raw_b = 1'b0;
        tick(5);
        check("t2_b_edge5", b, 1'b1);
        tick(1);
        check("t2_b_edge6", b, 1'b0);
        check("t2_b_fall", b_fall, 1'b1);
        check("t2_pv", pair_valid, 1'b1);
        tick(3);

        // raw_a rises, b unchanged
        raw_a = 1'b1;
        tick(5);
        check("t3_a_edge5", a, 1'b0);
        check("t3_a_rise_early", a_rise, 1'b0);
        tick(1);
        check("t3_a_edge6", a, 1'b1);
        check("t3_a_rise", a_rise, 1'b1);
        check("t3_a_fall", a_fall, 1'b0);
        check("t3_pv", pair_valid, 1'b1);
        check("t3_b", b, 1'b0);
        check("t3_b_rise", b_rise, 1'b0);
        tick(1);
        check("t3_a_rise_off", a_rise, 1'b0);
        check("t3_pv_off", pair_valid, 1'b0);

        // Return a to 0
        raw_a = 1'b0;
        tick(6);
        check("t4_a_fall", a_fall, 1'b1);
        check("t4_a_low", a, 1'b0);
        tick(3);

        // Bounce 1,0,1,0,1,0 then settle 1
        seen_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            raw_a = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick_watch(1);
        end
        raw_a = 1'b1;
        tick_watch(5);
        check("t5_bounce_quiet", seen_pulse, 1'b0);
        check("t5_a_edge5", a, 1'b0);
        tick(1);
        check("t5_a_edge6", a, 1'b1);
        check("t5_a_rise", a_rise, 1'b1);
        tick(1);
        check("t5_a_rise_off", a_rise, 1'b0);

        raw_a = 1'b0;
        tick(9);
        check("t6_a_low", a, 1'b0);

        // 3-cycle glitch rejected
        seen_pulse = 1'b0;
        raw_a = 1'b1;
        tick_watch(3);
        raw_a = 1'b0;
        tick_watch(10);
        check("t6_glitch_a", a, 1'b0);
        check("t6_glitch_quiet", seen_pulse, 1'b0);

        // Both rise together, then both fall together
        raw_a = 1'b1;
        raw_b = 1'b1;
        tick(5);
        check("t7_a_edge5", a, 1'b0);
        check("t7_b_edge5", b, 1'b0);
        tick(1);
        check("t7_a", a, 1'b1);
        check("t7_b", b, 1'b1);
        check("t7_a_rise", a_rise, 1'b1);
        check("t7_b_rise", b_rise, 1'b1);
        check("t7_pv", pair_valid, 1'b1);
        tick(1);
        check("t7_pv_off", pair_valid, 1'b0);
        check("t7_a_rise_off", a_rise, 1'b0);
        tick(2);
        raw_a = 1'b0;
        raw_b = 1'b0;
        tick(6);
        check("t7_a_fall", a_fall, 1'b1);
        check("t7_b_fall", b_fall, 1'b1);
        check("t7_a_rise_x", a_rise, 1'b0);
        check("t7_pv_fall", pair_valid, 1'b1);
        tick(1);
        check("t7_pv_fall_off", pair_valid, 1'b0);
        tick(3);

        // Reset mid-debounce restarts the count
        raw_a = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        check("t8_rst_a", a, 1'b0);
        check("t8_rst_pv", pair_valid, 1'b0);
        tick(1);
        check("t8_rst_a2", a, 1'b0);
        check("t8_rst_rise", a_rise, 1'b0);
        rst = 1'b0;
        tick(5);
        check("t8_a_edge5", a, 1'b0);
        check("t8_rise_early", a_rise, 1'b0);
        tick(1);
        check("t8_a_edge6", a, 1'b1);
        check("t8_a_rise", a_rise, 1'b1);
        check("t8_pv", pair_valid, 1'b1);
        tick(1);
        check("t8_a_rise_off", a_rise, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
